// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared constants and helpers for the fifo_flags buffer: default geometry
//   and flag thresholds, a constant clog2, and the occupancy-count width.
//   No ports.
package fifo_pkg;

   localparam int unsigned DEF_DEPTH         = 8;
   localparam int unsigned DEF_WIDTH         = 8;
   localparam int unsigned DEF_AFULL_THRESH  = 6;
   localparam int unsigned DEF_AEMPTY_THRESH = 2;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Count has to represent 0..depth inclusive, so one bit more than the pointers.
   function automatic int unsigned count_width(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//   Simple dual-port storage for fifo_flags: depth x width words, synchronous
//   write, registered read (data one cycle after re_i). With FIFO_FWFT_EN
//   defined the read port is combinational (rdata_o = mem[raddr_i]).
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset (clears the read register only)
//   we_i     write enable,  waddr_i write address, wdata_i write data
//   re_i     read enable,   raddr_i read address
//   rdata_o  read data
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned depth = DEF_DEPTH,
   parameter int unsigned width = DEF_WIDTH,
   parameter int unsigned aw    = clog2(depth)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             we_i,
   input  logic [aw-1:0]    waddr_i,
   input  logic [width-1:0] wdata_i,
   input  logic             re_i,
   input  logic [aw-1:0]    raddr_i,
   output logic [width-1:0] rdata_o
);

   logic [width-1:0] mem_q [depth];

   // Storage is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

`ifdef FIFO_FWFT_EN
   logic unused_rd_ctrl;
   assign unused_rd_ctrl = reset_i ^ re_i;

   assign rdata_o = mem_q[raddr_i];
`else
   logic [width-1:0] rdata_d, rdata_q;

   // Holds the last word read when no read is accepted.
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) rdata_d = mem_q[raddr_i];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) rdata_q <= '0;
      else         rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/fifo_flags.sv
// fifo_flags
//   Synchronous FIFO with occupancy count, programmable almost-full /
//   almost-empty flags and sticky overflow / underflow error flags.
//   Optional first-word fall-through read port: define FIFO_FWFT_EN.
// Ports:
//   clk_i, reset_i (sync, active high)
//   din_i, wr_en_i           write side
//   rd_en_i, dout_o          read side (1-cycle latency, or FWFT)
//   clr_err_i                clears overflow_o / underflow_o
//   full_o, empty_o, almost_full_o, almost_empty_o, count_o
//   overflow_o, underflow_o  sticky error flags
module fifo_flags
   import fifo_pkg::*;
#(
   parameter int unsigned depth         = DEF_DEPTH,
   parameter int unsigned width         = DEF_WIDTH,
   parameter int unsigned afull_thresh  = DEF_AFULL_THRESH,
   parameter int unsigned aempty_thresh = DEF_AEMPTY_THRESH
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [width-1:0]              din_i,
   input  logic                          wr_en_i,
   input  logic                          rd_en_i,
   input  logic                          clr_err_i,
   output logic [width-1:0]              dout_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic                          almost_full_o,
   output logic                          almost_empty_o,
   output logic [count_width(depth)-1:0] count_o,
   output logic                          overflow_o,
   output logic                          underflow_o
);

   localparam int unsigned AW = clog2(depth);
   localparam int unsigned CW = count_width(depth);

   localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
   localparam logic [CW-1:0] AFULL_C  = CW'(afull_thresh);
   localparam logic [CW-1:0] AEMPTY_C = CW'(aempty_thresh);

   logic [AW-1:0] wr_ptr_d, wr_ptr_q;
   logic [AW-1:0] rd_ptr_d, rd_ptr_q;
   logic [CW-1:0] count_d, count_q;
   logic          ovf_d, ovf_q;
   logic          udf_d, udf_q;
   logic          wr_acc, rd_acc;

   // Flags come only from the registered count.
   assign full_o         = (count_q == DEPTH_C);
   assign empty_o        = (count_q == '0);
   assign almost_full_o  = (count_q >= AFULL_C);
   assign almost_empty_o = (count_q <= AEMPTY_C);
   assign count_o        = count_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = udf_q;

   assign wr_acc = wr_en_i && !full_o;
   assign rd_acc = rd_en_i && !empty_o;

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Sticky errors: a new error in the same cycle as a clear wins.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (clr_err_i) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (wr_en_i && full_o)  ovf_d = 1'b1;
      if (rd_en_i && empty_o) udf_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_mem #(
      .depth (depth),
      .width (width),
      .aw    (AW)
   ) u_mem (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .we_i    (wr_acc && !reset_i),
      .waddr_i (wr_ptr_q),
      .wdata_i (din_i),
      .re_i    (rd_acc && !reset_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (dout_o)
   );

endmodule

// File: tb/tb_fifo_flags.sv
module tb_fifo_flags;

   localparam int DEPTH  = 8;
   localparam int AFULL  = 6;
   localparam int AEMPTY = 2;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic [7:0] din_i = '0;
   logic       wr_en_i = 1'b0;
   logic       rd_en_i = 1'b0;
   logic       clr_err_i = 1'b0;
   logic [7:0] dout_o;
   logic       full_o, empty_o, almost_full_o, almost_empty_o;
   logic [3:0] count_o;
   logic       overflow_o, underflow_o;

   fifo_flags dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .din_i          (din_i),
      .wr_en_i        (wr_en_i),
      .rd_en_i        (rd_en_i),
      .clr_err_i      (clr_err_i),
      .dout_o         (dout_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .count_o        (count_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a queue of stored words plus the expected output word.
   logic [7:0] mq[$];
   logic [7:0] m_dout = '0;
   bit         m_dout_vld = 1'b0;
   bit         m_ovf = 1'b0;
   bit         m_udf = 1'b0;

   function automatic logic [9:0] exp_status();
      int n;
      n = mq.size();
      return {4'(n), n == DEPTH, n == 0, n >= AFULL, n <= AEMPTY, m_ovf, m_udf};
   endfunction

   function automatic logic [9:0] obs_status();
      return {count_o, full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o};
   endfunction

   // One clock with the given inputs; model advances from pre-edge state.
   task automatic drive(input bit wr, input bit rd, input bit clr, input bit rst,
                        input logic [7:0] d);
      bit was_full, was_empty;
      wr_en_i = wr; rd_en_i = rd; clr_err_i = clr; reset_i = rst; din_i = d;
      @(posedge clk_i);
      if (rst) begin
         mq.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         if (rd && !was_empty) m_dout = mq.pop_front();
         if (wr && !was_full)  mq.push_back(d);
         if (wr && was_full)   m_ovf = 1'b1;
         else if (clr)         m_ovf = 1'b0;
         if (rd && was_empty)  m_udf = 1'b1;
         else if (clr)         m_udf = 1'b0;
      end
`ifdef FIFO_FWFT_EN
      m_dout_vld = (mq.size() > 0);
      if (m_dout_vld) m_dout = mq[0];
`else
      m_dout_vld = 1'b1;
`endif
      #1;
      wr_en_i = 1'b0; rd_en_i = 1'b0; clr_err_i = 1'b0; reset_i = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, i < 2, 8'h00);
         n_cmp++;
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL reset_status cyc=%0d got=%h exp=%h", i, obs_status(), exp_status());
         end
         if (m_dout_vld) begin
            n_cmp++;
            if (dout_o !== m_dout) begin
               n_err++;
               $display("FAIL reset_dout cyc=%0d got=%h exp=%h", i, dout_o, m_dout);
            end
         end
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 2 * DEPTH; i++) begin
         if (i < DEPTH) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
         else           drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         n_cmp++;
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL fill_drain_status step=%0d got=%h exp=%h", i, obs_status(), exp_status());
         end
         if (m_dout_vld) begin
            n_cmp++;
            if (dout_o !== m_dout) begin
               n_err++;
               $display("FAIL fill_drain_dout step=%0d got=%h exp=%h", i, dout_o, m_dout);
            end
         end
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h50 + i));
      // 2 overflow pulses, 2 idle, 1 clear, then drain (0xAA must never surface)
      for (int i = 0; i < 5 + DEPTH; i++) begin
         if (i < 2)       drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
         else if (i < 4)  drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         else if (i == 4) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
         else             drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         n_cmp++;
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL overflow_status step=%0d got=%h exp=%h", i, obs_status(), exp_status());
         end
         if (m_dout_vld) begin
            n_cmp++;
            if (dout_o !== m_dout) begin
               n_err++;
               $display("FAIL overflow_dout step=%0d got=%h exp=%h", i, dout_o, m_dout);
            end
         end
      end
   endtask

   task automatic test_underflow();
      // empty: read, idle, clear+read together, clear alone
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            1: drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            2: drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            default: drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
         endcase
         n_cmp++;
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL underflow_status step=%0d got=%h exp=%h", i, obs_status(), exp_status());
         end
         if (m_dout_vld) begin
            n_cmp++;
            if (dout_o !== m_dout) begin
               n_err++;
               $display("FAIL underflow_dout step=%0d got=%h exp=%h", i, dout_o, m_dout);
            end
         end
      end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
      for (int i = 0; i < 24; i++) begin
         if (i < 20) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
         else        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         n_cmp++;
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL wrap_status step=%0d got=%h exp=%h", i, obs_status(), exp_status());
         end
         if (m_dout_vld) begin
            n_cmp++;
            if (dout_o !== m_dout) begin
               n_err++;
               $display("FAIL wrap_dout step=%0d got=%h exp=%h", i, dout_o, m_dout);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
      // reset with 5 stored (and a write/read pending), write 0x33, read it back
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
            1: drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
            2: drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            default: drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         endcase
         n_cmp++;
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL reset_mid_status step=%0d got=%h exp=%h", i, obs_status(), exp_status());
         end
         if (m_dout_vld) begin
            n_cmp++;
            if (dout_o !== m_dout) begin
               n_err++;
               $display("FAIL reset_mid_dout step=%0d got=%h exp=%h", i, dout_o, m_dout);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
               $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2,
               8'($urandom_range(0, 255)));
         n_cmp++;
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL random_status cyc=%0d got=%h exp=%h", i, obs_status(), exp_status());
         end
         if (m_dout_vld) begin
            n_cmp++;
            if (dout_o !== m_dout) begin
               n_err++;
               $display("FAIL random_dout cyc=%0d got=%h exp=%h", i, dout_o, m_dout);
            end
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Next-generation synchronous FIFO: parametrised width/depth storage plus occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Single clock domain; sits between producer and consumer datapaths as the general-purpose buffer for new blocks.
- Supersedes plain `fifo` where flow control needs early warning or error reporting.

Parameters:
- depth, 8, number of entries; power of two, >= 2
- width, 8, data word width in bits
- afull_thresh, 6, almost_full_o asserted when count >= afull_thresh (1..depth)
- aempty_thresh, 2, almost_empty_o asserted when count <= aempty_thresh (0..depth-1)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- din_i  in  width  write data
- wr_en_i  in  1  write request
- rd_en_i  in  1  read request
- clr_err_i  in  1  clears sticky error flags
- dout_o  out  width  read data
- full_o  out  1  count == depth
- empty_o  out  1  count == 0
- almost_full_o  out  1  count >= afull_thresh
- almost_empty_o  out  1  count <= aempty_thresh
- count_o  out  $clog2(depth)+1  current occupancy 0..depth
- overflow_o  out  1  sticky: write attempted while full
- underflow_o  out  1  sticky: read attempted while empty

Behaviour:
- Reset (synchronous, reset_i high at clock edge): wr/rd pointers 0, count_o 0, dout_o 0, empty_o 1, almost_empty_o 1, full_o 0, almost_full_o 0 (unless afull_thresh==0, disallowed), overflow_o 0, underflow_o 0. Memory contents not cleared. Reset mid-transfer discards all stored words; reset dominates wr_en_i/rd_en_i/clr_err_i in that cycle.
- Write accepted iff wr_en_i && !full_o: mem[wr_ptr] <= din_i, wr_ptr increments, wraps depth-1 -> 0.
- Read accepted iff rd_en_i && !empty_o: rd_ptr increments with same wrap; dout_o <= mem[rd_ptr] (1-cycle latency, data valid the cycle after acceptance). dout_o holds its value when no read is accepted.
- Acceptance uses flag values at the clock edge; full_o with simultaneous wr+rd: read accepted, write rejected (overflow set). Empty with simultaneous wr+rd: write accepted, read rejected (underflow set).
- Count: +1 write-only, -1 read-only, unchanged when both or neither accepted. Never exceeds depth nor goes below 0.
- All flags decoded from the registered count; no combinational path from wr_en_i/rd_en_i to any output.
- overflow_o set on wr_en_i && full_o; underflow_o set on rd_en_i && empty_o; both cleared by clr_err_i. Set has priority over clear in the same cycle.
- Rejected operations do not modify pointers, count, memory or dout_o.

Optional Feature:
- Macro FIFO_FWFT_EN (first-word fall-through).
- Defined: dout_o continuously presents mem[rd_ptr] whenever !empty_o (0-cycle latency); rd_en_i acts as acknowledge/pop; dout_o is don't-care when empty_o. Reset value of dout_o is irrelevant and not checked.
- Undefined: standard registered 1-cycle read as above.
- Flag, count and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg: clog2 constant function, default threshold constants, count-width derivation.
- One sub-module fifo_mem: simple dual-port RAM (depth x width), synchronous write, registered read port (combinational read port when FIFO_FWFT_EN).
- Pointer/count/flag control stays in fifo_flags.

Test Plan:
- Reset then idle -> empty_o=1, almost_empty_o=1, count_o=0, dout_o=0, errors 0.
- Write 8 words 0x10..0x17 -> count_o steps 1..8; almost_full_o rises at count 6; full_o at 8; read 8 -> dout_o 0x10..0x17 in order, each one cycle after rd_en_i, then empty_o=1.
- When full, pulse wr_en_i with 0xAA -> overflow_o=1 and stays 1; count_o=8; 0xAA never read. Pulse clr_err_i -> overflow_o=0.
- When empty, pulse rd_en_i -> underflow_o=1 and dout_o unchanged; clr_err_i and rd_en_i on empty in the same cycle -> underflow_o stays 1.
- Wrap-around with count 4: simultaneous wr+rd for 20 cycles -> count_o constant 4; data order preserved across pointer wrap.
- Reset asserted with count 5 -> next cycle count_o=0, empty_o=1; a subsequent write of 0x33 reads back 0x33. With FIFO_FWFT_EN, 0x33 appears on dout_o the cycle after the write.
